trojan_guard_controller: RTL
============================

// Module: trojan_guard_controller
// PURPOSE
//  Initiator-side controller for the Trojan-protected 4-bit ALU.
//  Accepts operation requests on a valid/ready interface and drives a/b/opcode into the ALU.
//  Captures result and mitigation_active and returns them on a valid/ready response interface.
//  Counts mitigation events and escalates to a LOCKED state when ALERT_THRESH events occur
//  within a WINDOW-cycle window. Sits between the host bus and the protected ALU.
// PARAMETERS
//  DATA_W        4    operand/result width (matches protected ALU)
//  ALERT_THRESH  3    mitigation events per window that trigger lockout (>=1)
//  WINDOW        16   window length in clk cycles (>=2)
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  req_valid      in   1       request valid
//  req_ready      out  1       request accepted when req_valid&req_ready
//  req_a, req_b   in   DATA_W  operands
//  req_op         in   2       00 add, 01 sub, 10 and, 11 xor
//  alu_a, alu_b   out  DATA_W  registered operands to protected ALU
//  alu_op         out  2       registered opcode to protected ALU
//  alu_result     in   DATA_W  ALU result (combinational from alu_*)
//  alu_mitigation in   1       ALU mitigation_active
//  rsp_valid      out  1       response valid
//  rsp_ready      in   1       response consumed when rsp_valid&rsp_ready
//  rsp_result     out  DATA_W  captured result
//  rsp_flag       out  1       1 = Trojan mitigation occurred on this op
//  alert_count    out  8       saturating total mitigation events since reset
//  lockout        out  1       1 while in LOCKED
//  unlock         in   1       single-cycle pulse; leaves LOCKED
// BEHAVIOUR
//  Reset: state IDLE; every output 0; window and alert counters 0.
//  FSM IDLE -> ISSUE -> RESP -> IDLE|LOCKED; LOCKED -> IDLE.
//  IDLE: req_ready=1. On handshake at edge E0, alu_a/b/op <= req_*; go to ISSUE.
//  ISSUE: one settle cycle. At E1 capture: rsp_result <= alu_mitigation ? 0 : alu_result;
//    rsp_flag <= alu_mitigation; rsp_valid <= 1; go to RESP. Latency: rsp_valid high 1 cycle after accept.
//  RESP: rsp_* held stable until rsp_ready. On handshake: rsp_valid <= 0;
//    go to LOCKED if win_alerts >= ALERT_THRESH, else IDLE. Max throughput 1 op / 3 cycles.
//  req_ready=0 in ISSUE, RESP and LOCKED; req_* ignored there.
//  Window: free-running counter 0..WINDOW-1, wraps to 0 and clears win_alerts.
//    If wrap and capture of a mitigation coincide, win_alerts = 1 (alert counts in new window).
//  Capture with alu_mitigation=1: win_alerts+1 (saturate at ALERT_THRESH); alert_count+1 (saturate 255).
//  LOCKED: lockout=1. unlock -> IDLE, win_alerts=0, window counter=0; alert_count retained.
//    unlock outside LOCKED is ignored.
//  Async reset at any point: pending request/response discarded; reset values restored immediately.
//  Arithmetic: no arithmetic on data; DATA_W-bit results pass through unchanged (ALU wraps).
// CONFIGURATION
//  TROJAN_GUARD_SCRUB_EN defined: alu_a/alu_b/alu_op forced to 0 in IDLE, RESP and LOCKED.
//    Operands are non-zero only in ISSUE, which minimises exposure of trigger patterns.
//  Not defined: alu_* hold the last issued values until the next accepted request.
// TESTING
//  Add 0011+0101 op 00, rsp_ready=1 -> rsp_valid 1 cycle after accept; result 1000; flag 0.
//  Trigger a=1010 b=0101 op 11 -> rsp_result 0000; rsp_flag 1; alert_count 1; lockout 0.
//  3 triggers within 16 cycles -> lockout=1 and req_ready=0 after 3rd rsp handshake;
//    unlock pulse -> IDLE, req_ready=1, alert_count stays 3.
//  2 triggers, idle until >16 cycles pass (window wraps), 3rd trigger -> lockout stays 0.
//  Hold rsp_ready=0 for 5 cycles on a sub 1010-0100 -> rsp_result 0110 stable, req_ready 0 throughout.
//  Assert rst_n=0 while in RESP -> rsp_valid, lockout and alert_count read 0 immediately;
//    req_ready=1 after release. With SCRUB_EN, alu_* read 0 in IDLE.

Source files
------------

// File: rtl/trojan_guard_controller.sv
// Host-side valid/ready controller for the Trojan-protected ALU with windowed mitigation lockout.
// Optional: define TROJAN_GUARD_SCRUB_EN to drive alu_a/alu_b/alu_op to zero outside ISSUE.
module trojan_guard_controller #(
    parameter int DATA_W       = 4,
    parameter int ALERT_THRESH = 3,
    parameter int WINDOW       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [1:0]        req_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_mitigation,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_flag,
    output logic [7:0]        alert_count,
    output logic              lockout,
    input  logic              unlock
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [7:0] THRESH = 8'(ALERT_THRESH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RESP   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_flag_q, rsp_flag_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        alert_count_q, alert_count_d;
    logic [7:0]        win_alerts_q, win_alerts_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic              wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            rsp_result_q  <= '0;
            rsp_flag_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            alert_count_q <= '0;
            win_alerts_q  <= '0;
            win_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flag_q    <= rsp_flag_d;
            rsp_valid_q   <= rsp_valid_d;
            alert_count_q <= alert_count_d;
            win_alerts_q  <= win_alerts_d;
            win_cnt_q     <= win_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        rsp_result_d  = rsp_result_q;
        rsp_flag_d    = rsp_flag_q;
        rsp_valid_d   = rsp_valid_q;
        alert_count_d = alert_count_q;

        // The window wrap clears the per-window tally; a coincident alert lands in the new window.
        wrap         = (win_cnt_q == WIN_LAST);
        win_cnt_d    = wrap ? '0 : win_cnt_q + WIN_W'(1);
        win_alerts_d = wrap ? '0 : win_alerts_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_a_d  = req_a;
                    alu_b_d  = req_b;
                    alu_op_d = req_op;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                rsp_result_d = alu_mitigation ? '0 : alu_result;
                rsp_flag_d   = alu_mitigation;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
                if (alu_mitigation) begin
                    if (wrap) begin
                        win_alerts_d = 8'd1;
                    end else if (win_alerts_q < THRESH) begin
                        win_alerts_d = win_alerts_q + 8'd1;
                    end
                    if (alert_count_q != 8'hFF) begin
                        alert_count_d = alert_count_q + 8'd1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = (win_alerts_q >= THRESH) ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                if (unlock) begin
                    state_d      = IDLE;
                    win_cnt_d    = '0;
                    win_alerts_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with rst_n keeps req_ready low while reset is held, even though state is IDLE.
    assign req_ready   = rst_n && (state_q == IDLE);
    assign lockout     = (state_q == LOCKED);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_flag    = rsp_flag_q;
    assign alert_count = alert_count_q;

`ifdef TROJAN_GUARD_SCRUB_EN
    assign alu_a  = (state_q == ISSUE) ? alu_a_q  : '0;
    assign alu_b  = (state_q == ISSUE) ? alu_b_q  : '0;
    assign alu_op = (state_q == ISSUE) ? alu_op_q : '0;
`else
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
`endif

endmodule
